proc_mem_arbiter: RTL

- Two-to-one memory-port arbiter directly downstream of the processor's imem and dmem request/response streams.
- Merges both request streams onto one shared memory port. Routes each in-order memory response back to the port that issued the matching request.
- Lets a single-ported test memory or cache serve one core.
- Round-robin fairness; a small tag FIFO records the issuing port of every outstanding request.

---
 rtl/proc_mem_arbiter_pkg.sv | 26 ++
 rtl/proc_mem_arb_tag_fifo.sv | 68 ++++++
 rtl/proc_mem_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/proc_mem_arbiter_pkg.sv
// rtl/proc_mem_arbiter_pkg.sv - port ids and memory message types shared by the arbiter
package proc_mem_arbiter_pkg;

  localparam logic MEM_ARB_PORT_IMEM = 1'b0;
  localparam logic MEM_ARB_PORT_DMEM = 1'b1;

  localparam logic [2:0] MEM_MSG_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_MSG_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// File: rtl/proc_mem_arb_tag_fifo.sv
// rtl/proc_mem_arb_tag_fifo.sv - 1-bit circular FIFO holding the issuing port of each outstanding request
module proc_mem_arb_tag_fifo #(
  parameter int p_depth     = 4,
  parameter int p_cnt_nbits = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   push_data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   head_o,
  output logic [p_cnt_nbits-1:0] count_o
);

  localparam int c_ptr_nbits = $clog2(p_depth);
  localparam logic [p_cnt_nbits-1:0] c_depth = p_cnt_nbits'(p_depth);

  logic [p_depth-1:0]     slots_q, slots_d;
  logic [c_ptr_nbits-1:0] head_q, head_d;
  logic [c_ptr_nbits-1:0] tail_q, tail_d;
  logic [p_cnt_nbits-1:0] count_q, count_d;
  logic                   do_push, do_pop;

  assign full_o  = (count_q == c_depth);
  assign empty_o = (count_q == '0);
  assign head_o  = slots_q[head_q];
  assign count_o = count_q;

  // Full is judged on the registered count, so a same-cycle pop never admits a push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    slots_d = slots_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) begin
      slots_d[tail_q] = push_data_i;
      tail_d          = tail_q + c_ptr_nbits'(1);
    end
    if (do_pop) begin
      head_d = head_q + c_ptr_nbits'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + p_cnt_nbits'(1);
      2'b01:   count_d = count_q - p_cnt_nbits'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      slots_q <= slots_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/proc_mem_arbiter.sv
// rtl/proc_mem_arbiter.sv - round-robin 2:1 arbiter merging imem/dmem onto one in-order memory port
module proc_mem_arbiter
  import proc_mem_arbiter_pkg::*;
#(
  parameter int p_max_inflight = 4,
  parameter int p_cnt_nbits    = 3
) (
  input  logic                   clk,
  input  logic                   reset,

  input  mem_req_4B_t            req0_msg,
  input  logic                   req0_val,
  output logic                   req0_rdy,
  input  mem_req_4B_t            req1_msg,
  input  logic                   req1_val,
  output logic                   req1_rdy,

  output mem_resp_4B_t           resp0_msg,
  output logic                   resp0_val,
  input  logic                   resp0_rdy,
  output mem_resp_4B_t           resp1_msg,
  output logic                   resp1_val,
  input  logic                   resp1_rdy,

  output mem_req_4B_t            memreq_msg,
  output logic                   memreq_val,
  input  logic                   memreq_rdy,
  input  mem_resp_4B_t           memresp_msg,
  input  logic                   memresp_val,
  output logic                   memresp_rdy,

  output logic [p_cnt_nbits-1:0] inflight,
  output logic                   err
);

  logic gnt_val, gnt_id;
  logic full, empty, head_id;
  logic req_fire, resp_fire;
  logic prio_q, prio_d;
  logic err_q, err_d;

  always_comb begin
    gnt_val = req0_val || req1_val;
    gnt_id  = MEM_ARB_PORT_IMEM;
    if (req0_val && req1_val) begin
      gnt_id = prio_q;
    end else if (req1_val) begin
      gnt_id = MEM_ARB_PORT_DMEM;
    end
  end

  assign memreq_val = gnt_val && !full;
  assign memreq_msg = (gnt_id == MEM_ARB_PORT_DMEM) ? req1_msg : req0_msg;
  assign req0_rdy   = gnt_val && (gnt_id == MEM_ARB_PORT_IMEM) && !full && memreq_rdy;
  assign req1_rdy   = gnt_val && (gnt_id == MEM_ARB_PORT_DMEM) && !full && memreq_rdy;
  assign req_fire   = memreq_val && memreq_rdy;

  // Responses come back in request order, so the FIFO head names their destination.
  assign memresp_rdy = !empty && ((head_id == MEM_ARB_PORT_DMEM) ? resp1_rdy : resp0_rdy);
  assign resp0_val   = memresp_val && !empty && (head_id == MEM_ARB_PORT_IMEM);
  assign resp1_val   = memresp_val && !empty && (head_id == MEM_ARB_PORT_DMEM);
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign resp_fire   = memresp_val && memresp_rdy;

  proc_mem_arb_tag_fifo #(
    .p_depth     (p_max_inflight),
    .p_cnt_nbits (p_cnt_nbits)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_fire),
    .push_data_i (gnt_id),
    .pop_i       (resp_fire),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head_id),
    .count_o     (inflight)
  );

  always_comb begin
    prio_d = prio_q;
    err_d  = err_q;
    if (req_fire) begin
      prio_d = ~gnt_id;
    end
    if (memresp_val && empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= MEM_ARB_PORT_IMEM;
      err_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

endmodule
